seg_scan_ctrl: RTL



---
 rtl/seg_pkg.sv | 11 +
 rtl/seg_scan_ctrl_if.sv | 12 +
 rtl/hex7seg_dec.sv | 16 +
 rtl/seg_scan_ctrl.sv | 81 ++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment constants for the board display blocks
package seg_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_G = 6;
  localparam int SEG_DP = 7;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] HEX7 [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display content in from the datapath, anode/segment pins out
interface seg_scan_ctrl_if #(parameter int DIGITS = 4);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0] dp;
  logic [DIGITS-1:0] dig_en;
  logic lzb;
  logic [DIGITS-1:0] an_n;
  logic [7:0] seg_n;
  logic frame_done;
  modport master(output data, dp, dig_en, lzb, input an_n, seg_n, frame_done);
  modport slave(input data, dp, dig_en, lzb, output an_n, seg_n, frame_done);
endinterface

// File: rtl/hex7seg_dec.sv
// hex7seg_dec: nibble to active-low 7-segment code with decimal point and blanking
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg_n
);
  // blanking darkens only the a..g shapes; the decimal point stays independent
  always_comb begin
    seg_n = SEG_BLANK;
    seg_n[SEG_DP] = ~dp;
    seg_n[SEG_G:SEG_A] = blank ? 7'h7F : HEX7[nib];
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed common-anode 7-segment scanner with frame snapshot and dead time
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CLK_DIV = 100000,
  parameter int BLANK_CYC = 16
) (
  input logic clk,
  input logic rst_n,
  seg_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic load;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0] sh_dp;
  logic [DIGITS-1:0] sh_en;
  logic sh_lzb;
  logic [DIGITS-1:0] blank;
  logic lead;
  logic slot_end;
  logic last;
  logic on;
  logic [7:0] seg_d;
  assign slot_end = cnt == CW'(CLK_DIV - 1);
  assign last = idx == IW'(DIGITS - 1);
  assign on = int'(cnt) >= BLANK_CYC && sh_en[idx];
  // leading zeros blank from the top digit down; disabled digits count as zero, digit 0 always shows
  always_comb begin
    lead = sh_lzb;
    blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead = lead && (!sh_en[i] || sh_data[4*i +: 4] == 4'h0);
      blank[i] = lead;
    end
  end
  hex7seg_dec u_dec (
    .nib(sh_data[4*idx +: 4]),
    .dp(sh_dp[idx]),
    .blank(blank[idx]),
    .seg_n(seg_d)
  );
  // slot divider, digit index and end-of-frame strobe
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      idx <= slot_end ? (last ? '0 : idx + 1'b1) : idx;
      bus.frame_done <= slot_end && last;
    end
  // frame snapshot keeps each frame tear-free against mid-frame input changes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      load <= 1'b1;
      sh_data <= '0;
      sh_dp <= '0;
      sh_en <= '0;
      sh_lzb <= 1'b0;
    end else if (load || (slot_end && last)) begin
      load <= 1'b0;
      sh_data <= bus.data;
      sh_dp <= bus.dp;
      sh_en <= bus.dig_en;
      sh_lzb <= bus.lzb;
    end
  // registered pins: dark during dead time or for disabled digits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.an_n <= '1;
      bus.seg_n <= SEG_BLANK;
    end else begin
      bus.an_n <= on ? ~(DIGITS'(1) << idx) : '1;
      bus.seg_n <= on ? seg_d : SEG_BLANK;
    end
endmodule
